wavegen_sweep_ctrl: RTL and testbench
=====================================

# wavegen_sweep_ctrl

Frequency-sweep scheduler for the 12-bit CORDIC waveform generator. It sits in front of the generator and drives its `freq` tuning word. On a start pulse it steps the word from a start value to a stop value in fixed increments, holding each value for a programmable dwell. It supports single-shot, repeating and ping-pong sweeps, and reports progress through `busy`, `step_tick` and `done`.

## Interface
- `freq_width`, default 12: width of all frequency words; matches the generator's `freq` input.
- `DWELL_W`, default 16: width of the dwell counter and the `dwell` input.

Ports:
- `clock`, in, 1: the single clock.
- `resetn`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: pulse that launches a sweep; sampled only in IDLE.
- `abort`, in, 1: stops any sweep; higher priority than `start`.
- `f_start`, in, `freq_width`: first frequency word.
- `f_stop`, in, `freq_width`: final frequency word.
- `f_step`, in, `freq_width`: step magnitude, unsigned.
- `dwell`, in, `DWELL_W`: clock cycles each word is held.
- `mode`, in, 2: 00 single, 01 repeat, 10 ping-pong, 11 behaves as 00.
- `freq`, out, `freq_width`: registered tuning word; connects to the generator's `freq`.
- `busy`, out, 1: high while a sweep is running.
- `step_tick`, out, 1: one-cycle pulse in the first cycle of each new `freq` value.
- `done`, out, 1: one-cycle pulse when a single-mode sweep completes.

## Operation
- Two states, IDLE and RUN, plus registered `dwell_cnt`, `dir` and latched copies of all configuration inputs.
- All configuration is latched on the accepted `start`. Changes to the inputs during RUN have no effect.
- Effective values:
  - dwell_eff = max(`dwell`, 1).
  - step_eff = max(`f_step`, 1).
  - `dir` is up if `f_stop` >= `f_start`, else down.
- IDLE:
  - `start`=1 and `abort`=0 gives RUN, `freq`<=`f_start`, `dwell_cnt`<=0, `step_tick`<=1.
  - Otherwise the state and `freq` hold.
- RUN:
  - `dwell_cnt` increments every cycle.
  - When `dwell_cnt` == dwell_eff-1 it clears, and the end-of-dwell action below executes.
- End-of-dwell when `freq` != target (target is `f_stop` for the current leg):
  - Next = `freq` ± step_eff, computed in `freq_width`+1 bits.
  - If the result passes or reaches the target, or overflows/underflows, `freq`<=target.
  - Otherwise `freq`<=next.
  - `step_tick`<=1.
- End-of-dwell when `freq` == target:
  - Single: go to IDLE, `done`<=1, `freq` holds at target.
  - Repeat: `freq`<=latched `f_start`, `step_tick`<=1, stay in RUN.
  - Ping-pong: swap the latched start and stop, invert `dir`, then step one increment toward the new target (clamped), `step_tick`<=1.
- `abort`=1 in any state: go to IDLE next cycle, `freq` holds its current value, `dwell_cnt` clears, no `done`.
- `start` during RUN is ignored.
- `f_start` == `f_stop`: the word is held for one dwell. Single mode then finishes with `done`. Repeat and ping-pong hold the word indefinitely, with a `step_tick` every dwell.

## Timing
- Reset values (asynchronous): state IDLE, `freq`=0, `busy`=0, `step_tick`=0, `done`=0, `dwell_cnt`=0, `dir`=up.
- All outputs are registered; no combinational path from inputs to outputs.
- `start` accepted at edge N gives `busy`=1, `freq`=`f_start` and `step_tick`=1 in cycle N+1.
- Every `freq` value is held exactly dwell_eff cycles.
- Single sweep of K distinct words:
  - `busy` stays high for K·dwell_eff cycles.
  - `done` pulses in the first cycle with `busy`=0.
  - A new `start` is accepted in that same cycle.
- `abort` at edge M gives `busy`=0 in cycle M+1.
- `start` and `abort` asserted together in IDLE: stay in IDLE.
- `step_tick` and `done` are never high in the same cycle.

## Test plan
- Reset mid-sweep: deassert `resetn` asynchronously between clock edges -> `freq`=0 and `busy`=0 immediately; no `done` after release.
- Single up sweep, `f_start`=100, `f_stop`=130, `f_step`=10, `dwell`=3 -> `freq` reads 100,110,120,130, each for 3 cycles. Four `step_tick` pulses. `done` 12 cycles after `busy` rises, then `freq` stays 130.
- Clamp and overflow:
  - `f_start`=100, `f_stop`=125, `f_step`=10 -> 100,110,120,125.
  - `f_start`=4090, `f_stop`=4095, `f_step`=10 -> 4090,4095, with no wrap to a low value.
- Down sweep with zero fields, `f_start`=4000, `f_stop`=3990, `f_step`=4, `dwell`=0 -> 4000,3996,3992,3990, one cycle each. Then `done`.
- Ping-pong, `f_start`=10, `f_stop`=20, `f_step`=5, `dwell`=1 -> 10,15,20,15,10,15,20,… with `step_tick` every cycle. `abort` mid-sweep -> `busy`=0 next cycle, `freq` frozen, no `done`.
- Repeat, `f_start`=50, `f_stop`=60, `f_step`=10, `dwell`=2 -> 50,50,60,60,50,50,… Changing `f_stop` mid-sweep has no effect. A `start` pulse during RUN is ignored.

Source files
------------

// File: rtl/wavegen_sweep_ctrl.sv
// wavegen_sweep_ctrl
// Frequency-sweep scheduler that drives the CORDIC waveform generator's
// tuning word. A start pulse launches a sweep from f_start to f_stop in
// steps of f_step. Each word is held for `dwell` clock cycles. Single,
// repeat and ping-pong modes are supported.
//
// Ports:
//   clock, resetn       clock, asynchronous active-low reset
//   start, abort        launch (accepted in IDLE only) / stop (wins over start)
//   f_start, f_stop     first and final frequency word
//   f_step              unsigned step magnitude (0 treated as 1)
//   dwell               cycles each word is held (0 treated as 1)
//   mode                00 single, 01 repeat, 10 ping-pong, 11 single
//   freq                registered tuning word to the generator
//   busy                high while a sweep is running
//   step_tick           pulse in the first cycle of each new freq value
//   done                pulse when a single-mode sweep completes
//
// state | meaning
// IDLE  | waiting for start; freq holds its last value
// RUN   | sweeping; dwell_cnt times each word
module wavegen_sweep_ctrl #(
  parameter int freq_width = 12,
  parameter int DWELL_W    = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [freq_width-1:0] f_start,
  input  logic [freq_width-1:0] f_stop,
  input  logic [freq_width-1:0] f_step,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [1:0]            mode,
  output logic [freq_width-1:0] freq,
  output logic                  busy,
  output logic                  step_tick,
  output logic                  done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [freq_width-1:0] freq_q, freq_d;
  logic [freq_width-1:0] fstart_q, fstart_d;
  logic [freq_width-1:0] fstop_q, fstop_d;
  logic [freq_width-1:0] step_q, step_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [DWELL_W-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic                  dir_q, dir_d;       // 1 = up
  logic                  busy_q, busy_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;

  // One step toward tgt. The sum/difference is one bit wider so a carry
  // or borrow is visible; either one, or reaching/passing tgt, clamps.
  function automatic logic [freq_width-1:0] step_toward(
    input logic [freq_width-1:0] cur,
    input logic [freq_width-1:0] tgt,
    input logic [freq_width-1:0] stp,
    input logic                  up
  );
    logic [freq_width:0]   nxt;
    logic [freq_width-1:0] res;
    if (up) begin
      nxt = {1'b0, cur} + {1'b0, stp};
      res = (nxt[freq_width] || (nxt[freq_width-1:0] >= tgt)) ? tgt : nxt[freq_width-1:0];
    end else begin
      nxt = {1'b0, cur} - {1'b0, stp};
      res = (nxt[freq_width] || (nxt[freq_width-1:0] <= tgt)) ? tgt : nxt[freq_width-1:0];
    end
    return res;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      freq_q      <= '0;
      fstart_q    <= '0;
      fstop_q     <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      mode_q      <= '0;
      dir_q       <= 1'b1;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      fstart_q    <= fstart_d;
      fstop_q     <= fstop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    fstart_d    = fstart_q;
    fstop_d     = fstop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (abort) begin
          dwell_cnt_d = '0;
        end else if (start) begin
          state_d     = RUN;
          fstart_d    = f_start;
          fstop_d     = f_stop;
          step_d      = (f_step == '0) ? {{(freq_width-1){1'b0}}, 1'b1} : f_step;
          dwell_d     = (dwell == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : dwell;
          mode_d      = mode;
          dir_d       = (f_stop >= f_start);
          freq_d      = f_start;
          dwell_cnt_d = '0;
          tick_d      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          dwell_cnt_d = '0;
        end else if (dwell_cnt_q == dwell_q - 1'b1) begin
          dwell_cnt_d = '0;
          if (freq_q != fstop_q) begin
            freq_d = step_toward(freq_q, fstop_q, step_q, dir_q);
            tick_d = 1'b1;
          end else begin
            case (mode_q)
              2'b01: begin
                freq_d = fstart_q;
                tick_d = 1'b1;
              end
              2'b10: begin
                // Reverse the leg: the old start becomes the new target.
                fstart_d = fstop_q;
                fstop_d  = fstart_q;
                dir_d    = ~dir_q;
                freq_d   = step_toward(freq_q, fstart_q, step_q, ~dir_q);
                tick_d   = 1'b1;
              end
              default: begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            endcase
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  assign freq      = freq_q;
  assign busy      = busy_q;
  assign step_tick = tick_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wavegen_sweep_ctrl.sv
module tb_wavegen_sweep_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] f_start = '0;
  logic [11:0] f_stop = '0;
  logic [11:0] f_step = '0;
  logic [15:0] dwell = '0;
  logic [1:0]  mode = '0;
  logic [11:0] freq;
  logic        busy;
  logic        step_tick;
  logic        done;

  int checks = 0;
  int errors = 0;

  wavegen_sweep_ctrl #(.freq_width(12), .DWELL_W(16)) dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .mode(mode), .freq(freq), .busy(busy), .step_tick(step_tick), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0]       fs;
    logic [11:0]       fe;
    logic [11:0]       st;
    logic [15:0]       dw;
    logic [1:0]        md;
    int                n;
    logic [7:0][11:0]  w;
    bit                single;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (resetn && step_tick && done) begin
      errors++;
      $display("FAIL tick_done_overlap actual=1 required=0");
    end
  end

  task automatic add(input int i, input int fs, input int fe, input int st, input int dw,
                     input int md, input int n, input bit single,
                     input int w0, input int w1, input int w2, input int w3,
                     input int w4, input int w5, input int w6, input int w7);
    vecs[i].fs = 12'(fs); vecs[i].fe = 12'(fe); vecs[i].st = 12'(st);
    vecs[i].dw = 16'(dw); vecs[i].md = 2'(md); vecs[i].n = n; vecs[i].single = single;
    vecs[i].w[0] = 12'(w0); vecs[i].w[1] = 12'(w1); vecs[i].w[2] = 12'(w2);
    vecs[i].w[3] = 12'(w3); vecs[i].w[4] = 12'(w4); vecs[i].w[5] = 12'(w5);
    vecs[i].w[6] = 12'(w6); vecs[i].w[7] = 12'(w7);
  endtask

  // Launch from IDLE; returns sampling at the negedge of cycle N+1.
  task automatic launch(input logic [11:0] fs, input logic [11:0] fe, input logic [11:0] st,
                        input logic [15:0] dw, input logic [1:0] md);
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; mode = md; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int de;
    logic [11:0] last;
    de = (vecs[i].dw == 0) ? 1 : int'(vecs[i].dw);
    launch(vecs[i].fs, vecs[i].fe, vecs[i].st, vecs[i].dw, vecs[i].md);
    for (int k = 0; k < vecs[i].n; k++) begin
      for (int c = 0; c < de; c++) begin
        chk($sformatf("v%0d_freq_w%0d_c%0d", i, k, c), freq, vecs[i].w[k]);
        chk($sformatf("v%0d_busy_w%0d_c%0d", i, k, c), busy, 1);
        chk($sformatf("v%0d_tick_w%0d_c%0d", i, k, c), step_tick, (c == 0));
        chk($sformatf("v%0d_done_w%0d_c%0d", i, k, c), done, 0);
        if (!vecs[i].single && k == vecs[i].n - 1 && c == de - 1) abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
      end
    end
    last = vecs[i].w[vecs[i].n - 1];
    chk($sformatf("v%0d_end_busy", i), busy, 0);
    chk($sformatf("v%0d_end_done", i), done, vecs[i].single);
    chk($sformatf("v%0d_end_tick", i), step_tick, 0);
    chk($sformatf("v%0d_end_freq", i), freq, last);
    @(negedge clock);
    chk($sformatf("v%0d_post_done", i), done, 0);
    chk($sformatf("v%0d_post_freq", i), freq, last);
    chk($sformatf("v%0d_post_busy", i), busy, 0);
  endtask

  initial begin
    logic [11:0] rep_exp [8];

    add(0, 100, 130, 10, 3, 0, 4, 1, 100, 110, 120, 130, 0, 0, 0, 0);
    add(1, 100, 125, 10, 3, 0, 4, 1, 100, 110, 120, 125, 0, 0, 0, 0);
    add(2, 4090, 4095, 10, 2, 0, 2, 1, 4090, 4095, 0, 0, 0, 0, 0, 0);
    add(3, 4000, 3990, 4, 0, 0, 4, 1, 4000, 3996, 3992, 3990, 0, 0, 0, 0);
    add(4, 10, 20, 5, 1, 2, 7, 0, 10, 15, 20, 15, 10, 15, 20, 0);
    add(5, 50, 60, 10, 2, 1, 4, 0, 50, 60, 50, 60, 0, 0, 0, 0);
    add(6, 7, 7, 0, 2, 3, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    add(7, 7, 7, 3, 1, 1, 3, 0, 7, 7, 7, 0, 0, 0, 0, 0);
    add(8, 0, 4095, 4095, 1, 0, 2, 1, 0, 4095, 0, 0, 0, 0, 0, 0);
    add(9, 5, 0, 10, 1, 0, 2, 1, 5, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clock);
    chk("rst_freq", freq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", step_tick, 0);
    chk("rst_done", done, 0);
    resetn = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_vec(i);

    // start and abort together in IDLE
    f_start = 12'd300; f_stop = 12'd310; f_step = 12'd1; dwell = 16'd1; mode = 2'b00;
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_tick", step_tick, 0);
    chk("sa_freq", freq, 0);

    // Repeat sweep: config changes and a start pulse during RUN are ignored
    rep_exp = '{12'd50, 12'd50, 12'd60, 12'd60, 12'd50, 12'd50, 12'd60, 12'd60};
    launch(12'd50, 12'd60, 12'd10, 16'd2, 2'b01);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rep_freq_%0d", k), freq, rep_exp[k]);
      chk($sformatf("rep_busy_%0d", k), busy, 1);
      chk($sformatf("rep_tick_%0d", k), step_tick, (k % 2 == 0));
      start = (k == 1);
      if (k == 1) begin f_stop = 12'd200; f_start = 12'd0; f_step = 12'd1; mode = 2'b00; end
      if (k == 7) abort = 1'b1;
      @(negedge clock);
      start = 1'b0; abort = 1'b0;
    end
    chk("rep_abort_busy", busy, 0);
    chk("rep_abort_freq", freq, 60);
    chk("rep_abort_done", done, 0);

    // New start accepted in the done cycle
    launch(12'd7, 12'd7, 12'd1, 16'd1, 2'b00);
    chk("dc_busy0", busy, 1);
    chk("dc_freq0", freq, 7);
    @(negedge clock);
    chk("dc_done", done, 1);
    chk("dc_busy1", busy, 0);
    launch(12'd20, 12'd30, 12'd10, 16'd1, 2'b00);
    chk("dc_restart_busy", busy, 1);
    chk("dc_restart_freq", freq, 20);
    chk("dc_restart_tick", step_tick, 1);
    chk("dc_restart_done", done, 0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("dc_abort_busy", busy, 0);
    chk("dc_abort_freq", freq, 20);

    // Asynchronous reset in the middle of a sweep
    launch(12'd100, 12'd130, 12'd10, 16'd3, 2'b00);
    repeat (4) @(negedge clock);
    chk("ar_pre_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_freq", freq, 0);
    chk("ar_busy", busy, 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) begin
        chk($sformatf("ar_post_%0d_done", k), done, 0);
        chk($sformatf("ar_post_%0d_busy", k), busy, 0);
      end
    end
    chk("ar_end_done", done, 0);
    chk("ar_end_busy", busy, 0);
    chk("ar_end_freq", freq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
